// File: rtl/mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mc_ctrl_fsm
// Brief    : Multi-cycle MIPS control unit (IF/ID/EXE/MEM/WB sequencing,
//            datapath controls, retired-instruction counter, illegal flag).
// Revision : 1.0
// ============================================================================
module mc_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             PCWr,
    output logic [1:0]       PCSrc,
    output logic             IRWr,
    output logic             RFWr,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             DMWr,
    output logic             ALUSrc,
    output logic [2:0]       ALUOp,
    output logic             ExtOp,
    output logic             Luisel,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instr_cnt_q;
    logic             retire_d;

    logic is_r, is_j, is_beq, is_addi, is_addiu, is_andi, is_ori, is_lui, is_lw, is_sw;
    logic is_legal;

    always_comb begin
        is_r     = (op == 6'b000000) &&
                   ((funct == 6'b100001) || (funct == 6'b100011) || (funct == 6'b100100) ||
                    (funct == 6'b100101) || (funct == 6'b101010));
        is_j     = (op == 6'b000010);
        is_beq   = (op == 6'b000100);
        is_addi  = (op == 6'b001000);
        is_addiu = (op == 6'b001001);
        is_andi  = (op == 6'b001100);
        is_ori   = (op == 6'b001101);
        is_lui   = (op == 6'b001111);
        is_lw    = (op == 6'b100011);
        is_sw    = (op == 6'b101011);
        is_legal = is_r | is_j | is_beq | is_addi | is_addiu | is_andi | is_ori |
                   is_lui | is_lw | is_sw;
    end

    always_comb begin
        state_d  = S_IF;
        retire_d = 1'b0;
        PCWr     = 1'b0;
        PCSrc    = 2'b00;
        IRWr     = 1'b0;
        RFWr     = 1'b0;
        DMWr     = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        ALUSrc   = 1'b0;
        ALUOp    = 3'b000;
        ExtOp    = 1'b0;
        Luisel   = 1'b0;
        illegal  = 1'b0;

        case (state_q)
            S_IF: begin
                PCWr    = 1'b1;
                IRWr    = 1'b1;
                state_d = S_ID;
            end
            S_ID: begin
                if (is_j) begin
                    PCWr     = 1'b1;
                    PCSrc    = 2'b10;
                    retire_d = 1'b1;
                end else if (!is_legal) begin
                    illegal  = 1'b1;
                end else begin
                    state_d  = S_EXE;
                end
            end
            S_EXE: begin
                if (is_beq) begin
                    PCWr     = zero;
                    PCSrc    = 2'b01;
                    retire_d = 1'b1;
                end else if (is_lw || is_sw) begin
                    state_d  = S_MEM;
                end else begin
                    state_d  = S_WB;
                end
            end
            S_MEM: begin
                if (is_sw) begin
                    DMWr     = 1'b1;
                    retire_d = 1'b1;
                end else begin
                    state_d  = S_WB;
                end
            end
            S_WB: begin
                RFWr     = 1'b1;
                retire_d = 1'b1;
            end
            default: state_d = S_IF;
        endcase

        // Operand/ALU selects track op from decode until the instruction leaves.
        if (is_legal && (state_q == S_ID || state_q == S_EXE ||
                         state_q == S_MEM || state_q == S_WB)) begin
            RegDst   = is_r;
            MemtoReg = is_lw;
            ALUSrc   = is_addi | is_addiu | is_andi | is_ori | is_lui | is_lw | is_sw;
            ExtOp    = is_addi | is_addiu | is_lw | is_sw | is_beq;
            Luisel   = is_lui;
            if (is_r) begin
                case (funct)
                    6'b100011: ALUOp = 3'b001;
                    6'b100100: ALUOp = 3'b010;
                    6'b100101: ALUOp = 3'b011;
                    6'b101010: ALUOp = 3'b100;
                    default:   ALUOp = 3'b000;
                endcase
            end else if (is_beq) begin
                ALUOp = 3'b001;
            end else if (is_andi) begin
                ALUOp = 3'b010;
            end else if (is_ori) begin
                ALUOp = 3'b011;
            end else if (is_lui) begin
                ALUOp = 3'b101;
            end else begin
                ALUOp = 3'b000;
            end
        end

        if (rst) begin
            PCWr     = 1'b0;
            PCSrc    = 2'b00;
            IRWr     = 1'b0;
            RFWr     = 1'b0;
            DMWr     = 1'b0;
            RegDst   = 1'b0;
            MemtoReg = 1'b0;
            ALUSrc   = 1'b0;
            ALUOp    = 3'b000;
            ExtOp    = 1'b0;
            Luisel   = 1'b0;
            illegal  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IF;
            instr_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire_d) begin
                instr_cnt_q <= instr_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign state     = state_q;
    assign instr_cnt = instr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_ctrl_fsm
// Brief    : Randomized bench for mc_ctrl_fsm against an instruction-level model.
// Revision : 1.0
// ============================================================================
module tb_mc_ctrl_fsm;

    localparam int CNT_W = 4;

    localparam int C_ILL  = 0;
    localparam int C_R    = 1;
    localparam int C_J    = 2;
    localparam int C_BEQ  = 3;
    localparam int C_ADDI = 4;
    localparam int C_ANDI = 5;
    localparam int C_ORI  = 6;
    localparam int C_LUI  = 7;
    localparam int C_LW   = 8;
    localparam int C_SW   = 9;

    logic             clk = 1'b0;
    logic             rst;
    logic [5:0]       op, funct;
    logic             zero;
    logic             PCWr, IRWr, RFWr, RegDst, MemtoReg, DMWr, ALUSrc, ExtOp, Luisel, illegal;
    logic [1:0]       PCSrc;
    logic [2:0]       ALUOp, state;
    logic [CNT_W-1:0] instr_cnt;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    mc_ctrl_fsm #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .PCWr(PCWr), .PCSrc(PCSrc), .IRWr(IRWr), .RFWr(RFWr), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .DMWr(DMWr), .ALUSrc(ALUSrc), .ALUOp(ALUOp),
        .ExtOp(ExtOp), .Luisel(Luisel), .illegal(illegal), .state(state),
        .instr_cnt(instr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int classify(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'h00:   return (f == 6'h21 || f == 6'h23 || f == 6'h24 || f == 6'h25 || f == 6'h2A) ? C_R : C_ILL;
            6'h02:   return C_J;
            6'h04:   return C_BEQ;
            6'h08:   return C_ADDI;
            6'h09:   return C_ADDI;
            6'h0C:   return C_ANDI;
            6'h0D:   return C_ORI;
            6'h0F:   return C_LUI;
            6'h23:   return C_LW;
            6'h2B:   return C_SW;
            default: return C_ILL;
        endcase
    endfunction

    // Cycle counts per instruction class: the stage list IF,ID,EXE,(MEM),(WB) truncated.
    function automatic int path_len(input int c);
        case (c)
            C_ILL, C_J: return 2;
            C_BEQ:      return 3;
            C_LW:       return 5;
            default:    return 4;
        endcase
    endfunction

    function automatic int path_state(input int c, input int k);
        if (k < 3) return k;
        if (k == 3) return (c == C_LW || c == C_SW) ? 3 : 4;
        return 4;
    endfunction

    function automatic int alu_of(input int c, input logic [5:0] f);
        case (c)
            C_R: begin
                case (f)
                    6'h23:   return 1;
                    6'h24:   return 2;
                    6'h25:   return 3;
                    6'h2A:   return 4;
                    default: return 0;
                endcase
            end
            C_BEQ:   return 1;
            C_ANDI:  return 2;
            C_ORI:   return 3;
            C_LUI:   return 5;
            default: return 0;
        endcase
    endfunction

    task automatic check_cycle(input int c, input int k, input logic z, input logic [5:0] f);
        int st;
        bit sel;
        st  = path_state(c, k);
        sel = (st != 0) && (c != C_ILL);
        check_eq("state",    state,     st);
        check_eq("cnt",      instr_cnt, exp_cnt);
        check_eq("PCWr",     PCWr,      (st == 0) || (c == C_J && st == 1) || (c == C_BEQ && st == 2 && z));
        check_eq("PCSrc",    PCSrc,     (c == C_J && st == 1) ? 2 : ((c == C_BEQ && st == 2) ? 1 : 0));
        check_eq("IRWr",     IRWr,      st == 0);
        check_eq("RFWr",     RFWr,      st == 4);
        check_eq("DMWr",     DMWr,      c == C_SW && st == 3);
        check_eq("illegal",  illegal,   c == C_ILL && st == 1);
        check_eq("RegDst",   RegDst,    sel && c == C_R);
        check_eq("MemtoReg", MemtoReg,  sel && c == C_LW);
        check_eq("ALUSrc",   ALUSrc,    sel && (c == C_ADDI || c == C_ANDI || c == C_ORI ||
                                                c == C_LUI || c == C_LW || c == C_SW));
        check_eq("ExtOp",    ExtOp,     sel && (c == C_ADDI || c == C_LW || c == C_SW || c == C_BEQ));
        check_eq("Luisel",   Luisel,    sel && c == C_LUI);
        check_eq("ALUOp",    ALUOp,     sel ? alu_of(c, f) : 0);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_en"}, {PCWr, IRWr, RFWr, DMWr, illegal}, 0);
        check_eq({tag, "_sel"}, {PCSrc, RegDst, MemtoReg, ALUSrc, ALUOp, ExtOp, Luisel}, 0);
    endtask

    // Entered and left just after a falling edge; abort_k >= 0 pulses rst in that cycle.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z, input int abort_k);
        int c;
        op    = o;
        funct = f;
        zero  = z;
        c     = classify(o, f);
        for (int k = 0; k < path_len(c); k++) begin
            if (k > 0) @(negedge clk);
            if (k == abort_k) begin
                rst = 1'b1;
                #1;
                check_eq("abort_state", state, path_state(c, k));
                check_quiet("abort");
                @(negedge clk);
                rst     = 1'b0;
                exp_cnt = 0;
                return;
            end
            #1;
            check_cycle(c, k, z, f);
        end
        if (c != C_ILL) exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
        @(negedge clk);
    endtask

    logic [5:0] ops [10];
    logic [5:0] fns [5];

    initial begin
        ops = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
        fns = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A};
        rst   = 1'b1;
        op    = 6'h23;
        funct = 6'h00;
        zero  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_state", state, 0);
        check_eq("rst_cnt", instr_cnt, 0);
        check_quiet("rst");
        @(negedge clk);
        rst = 1'b0;

        run_instr(6'h0D, 6'h00, 1'b0, -1);
        run_instr(6'h0F, 6'h00, 1'b0, -1);
        run_instr(6'h09, 6'h00, 1'b0, -1);
        check_eq("cnt_after3", instr_cnt, 3);
        run_instr(6'h23, 6'h00, 1'b0, -1);
        run_instr(6'h2B, 6'h00, 1'b0, -1);
        run_instr(6'h04, 6'h00, 1'b1, -1);
        run_instr(6'h04, 6'h00, 1'b0, -1);
        run_instr(6'h02, 6'h00, 1'b0, -1);
        run_instr(6'h3F, 6'h00, 1'b0, -1);
        run_instr(6'h00, 6'h00, 1'b0, -1);
        for (int i = 0; i < 5; i++) run_instr(6'h00, fns[i], 1'b0, -1);
        run_instr(6'h23, 6'h00, 1'b0, 4);

        for (int i = 0; i < 80; i++) begin
            logic [5:0] o, f;
            int pick;
            pick = $urandom_range(0, 11);
            if (pick < 10) begin
                o = ops[pick];
                f = (o == 6'h00 && $urandom_range(0, 3) != 0) ? fns[$urandom_range(0, 4)] : 6'($urandom);
            end else begin
                o = 6'($urandom);
                f = 6'($urandom);
            end
            run_instr(o, f, 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1);
        end

        run_instr(6'h23, 6'h00, 1'b0, 2);
        for (int i = 0; i < 15; i++) run_instr(6'h02, 6'h00, 1'b0, -1);
        check_eq("cnt_max", instr_cnt, 15);
        run_instr(6'h02, 6'h00, 1'b0, -1);
        check_eq("cnt_wrap", instr_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
